matrix_seq: RTL

MATRIX_SEQ -- requirements
Module: matrix_seq

---
 rtl/matrix_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/matrix_seq.sv
// Tile transposer: collects SZJ vectors of SZI elements, emits SZI vectors of SZJ elements; out_valid the cycle after the last input.
// Valid/ready on both sides; optional MATRIX_SEQ_PINGPONG_EN adds a second bank so fill and drain overlap.
module matrix_seq #(
  parameter int SZI   = 4,
  parameter int SZJ   = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SZI*WIDTH-1:0] in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SZJ*WIDTH-1:0] out_vec,
  output logic                 out_last,
  output logic [15:0]          tiles_done
);
  localparam int WI = (SZI > 1) ? $clog2(SZI) : 1;
  localparam int WJ = (SZJ > 1) ? $clog2(SZJ) : 1;

  logic [WJ-1:0] wr_idx;
  logic [WI-1:0] rd_idx;
  logic          live;
  logic          in_hs, out_hs, wr_last, rd_last;

  assign in_hs   = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;
  assign wr_last = (wr_idx == WJ'(SZJ - 1));
  assign rd_last = (rd_idx == WI'(SZI - 1));
  assign out_last = out_valid & rd_last;

  // live holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live       <= 1'b0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      tiles_done <= '0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        wr_idx <= '0;
        rd_idx <= '0;
      end else begin
        if (in_hs)
          wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
        if (out_hs) begin
          rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
          if (rd_last)
            tiles_done <= tiles_done + 16'd1;
        end
      end
    end
  end

`ifdef MATRIX_SEQ_PINGPONG_EN
  logic [WIDTH-1:0] mem [2][SZI][SZJ];
  logic [1:0]       full, full_d;
  logic             wr_bank, rd_bank;

  assign in_ready  = live & ~full[wr_bank];
  assign out_valid = full[rd_bank];

  always_comb begin
    full_d = full;
    if (in_hs && wr_last)
      full_d[wr_bank] = 1'b1;
    if (out_hs && rd_last)
      full_d[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else if (flush) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full <= full_d;
      if (in_hs && wr_last)
        wr_bank <= ~wr_bank;
      if (out_hs && rd_last)
        rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs && !flush)
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < SZI; i++)
          for (int j = 0; j < SZJ; j++)
            if (wr_bank == 1'(b) && wr_idx == WJ'(j))
              mem[b][i][j] <= in_vec[i*WIDTH +: WIDTH];
  end

  always_comb begin
    out_vec = '0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < SZI; i++)
        for (int j = 0; j < SZJ; j++)
          if (rd_bank == 1'(b) && rd_idx == WI'(i))
            out_vec[j*WIDTH +: WIDTH] = mem[b][i][j];
  end
`else
  typedef enum logic {FILL, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem [SZI][SZJ];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_q <= FILL;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = live;
        if (in_hs && wr_last)
          state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_hs && rd_last)
          state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    if (flush)
      state_d = FILL;
  end

  always_ff @(posedge clk) begin
    if (in_hs && !flush)
      for (int i = 0; i < SZI; i++)
        for (int j = 0; j < SZJ; j++)
          if (wr_idx == WJ'(j))
            mem[i][j] <= in_vec[i*WIDTH +: WIDTH];
  end

  always_comb begin
    out_vec = '0;
    for (int i = 0; i < SZI; i++)
      for (int j = 0; j < SZJ; j++)
        if (rd_idx == WI'(i))
          out_vec[j*WIDTH +: WIDTH] = mem[i][j];
  end
`endif

endmodule
